vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Free-running VGA raster timing generator for the 800x600@60 Hz, 40 MHz pixel-clock mode. It produces the hcount/vcount/sync/blank bundle consumed directly by the background drawing stage, which is the first stage of the rendering pipeline. All outputs are registered and mutually cycle-aligned. A clock-enable allows stall and test control; a one-cycle frame_start pulse marks the first pixel of each frame.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, hsync width (pixels)
H_BP, 88, horizontal back porch (pixels); H_TOTAL = sum = 1056
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync width (lines)
V_BP, 23, vertical back porch (lines); V_TOTAL = sum = 628
HS_POL, 1, hsync active level (1 = active-high)
VS_POL, 1, vsync active level (1 = active-high)

Ports:
pclk  input  1  pixel clock, 40 MHz
rst  input  1  reset, synchronous, active-low
ce  input  1  count enable; counters advance only when high
hcount  output  11  current pixel column, 0..H_TOTAL-1
hsync  output  1  horizontal sync, level per HS_POL
hblnk  output  1  horizontal blanking, high when hcount >= H_ACTIVE
vcount  output  11  current line, 0..V_TOTAL-1
vsync  output  1  vertical sync, level per VS_POL
vblnk  output  1  vertical blanking, high when vcount >= V_ACTIVE
frame_start  output  1  one-cycle pulse when counters enter (0,0) via wrap

Behaviour:
- Reset: rst sampled low on a pclk edge -> hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=~HS_POL, vsync=~VS_POL, frame_start=0. rst overrides ce. Reset mid-line or mid-frame restarts at (0,0) on the next edge, with no frame_start pulse for that restart.
- Counting, on an edge with ce=1: hcount = hcount+1; at H_TOTAL-1, hcount wraps to 0 and vcount increments. At vcount=V_TOTAL-1 with hcount=H_TOTAL-1, both wrap to 0.
- ce=0: every output holds its value, except frame_start, which is forced to 0. A pulse never lasts longer than one cycle.
- Alignment: every output is registered from the next-state counter values. In any cycle, the flags describe the hcount/vcount presented in that same cycle, with zero skew between bundle members.
- Sync windows:
  - hsync active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 840..967.
  - vsync active for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 601..604, for the entire line including hblnk.
- Blanking:
  - hblnk = (hcount >= 800).
  - vblnk = (vcount >= 600).
  - Active video = ~hblnk & ~vblnk.
- frame_start: 1 in exactly the cycle where the outputs show (0,0) reached by wrap from (H_TOTAL-1, V_TOTAL-1) with ce=1.
- Widths: counters are 11 bit unsigned. The implementation must support H_TOTAL and V_TOTAL up to 2047; larger values are out of scope. Comparisons use parameter-derived constants only, with no multipliers.
- Period: line = 1056 enabled cycles; frame = 1056*628 = 663168 enabled cycles.
- Structure: a single always block for registers plus combinational next-state logic.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release with ce=1 -> first cycle shows (0,0), hblnk=0, vblnk=0, hsync=0, vsync=0, frame_start=0. After 1 cycle hcount=1.
- Line timing: run one line from reset -> hblnk rises at hcount=800; hsync high exactly for hcount 840..967 (128 cycles); at hcount=1055 the next cycle shows hcount=0, vcount=1.
- Frame timing: run 663168 cycles -> vblnk high for vcount 600..627; vsync high for vcount 601..604 only. Outputs return to (0,0) with frame_start=1 for exactly one cycle, then 0 at (1,0).
- ce stall: with ce toggling 1,0,0,1 at hcount=10 -> hcount sequence 10,11,11,11,12. Stall at wrap (1055,627) -> frame_start=0 while held, then pulses once when (0,0) is reached.
- Mid-frame reset: assert rst at (500,300) -> next edge shows (0,0), vblnk=0, frame_start=0. Counting resumes normally after release.
- Polarity: HS_POL=0, VS_POL=0 -> hsync and vsync idle high and go low over the same windows (840..967 and 601..604); reset values are 1.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// VGA raster timing bundle: count enable in, hcount/vcount/sync/blank/frame_start out.
// Latency: n/a (signal container only).
// Backpressure: none; the consumer may only stall the raster through ce.
interface vga_timing_gen_if;
   logic        ce;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic        frame_start;

   // Timing generator side: receives ce, drives the raster bundle.
   modport master (
      input  ce,
      output hcount, hsync, hblnk, vcount, vsync, vblnk, frame_start
   );

   // Drawing-stage side: drives ce, consumes the raster bundle.
   modport slave (
      output ce,
      input  hcount, hsync, hblnk, vcount, vsync, vblnk, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator (default 800x600@60, 40 MHz pixel clock).
// Latency: all outputs registered from next-state counters, mutually cycle-aligned.
// Backpressure: ce=0 freezes the raster; frame_start is forced low while frozen.
module vga_timing_gen #(
   parameter int   H_ACTIVE = 800,
   parameter int   H_FP     = 40,
   parameter int   H_SYNC   = 128,
   parameter int   H_BP     = 88,
   parameter int   V_ACTIVE = 600,
   parameter int   V_FP     = 1,
   parameter int   V_SYNC   = 4,
   parameter int   V_BP     = 23,
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1
) (
   input  logic              pclk,
   input  logic              rst,
   vga_timing_gen_if.master  vga
);

   // All window edges are elaboration-time constants, so compares need no arithmetic.
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [10:0] hcount_q, hcount_d;
   logic [10:0] vcount_q, vcount_d;
   logic        hsync_q, hsync_d;
   logic        hblnk_q, hblnk_d;
   logic        vsync_q, vsync_d;
   logic        vblnk_q, vblnk_d;
   logic        frame_start_q, frame_start_d;

   // Next raster position, then every flag decoded from that same next position
   // so the registered bundle has zero skew between counters and flags.
   always_comb begin
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      frame_start_d = 1'b0;
      if (vga.ce) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            if (vcount_q == V_LAST) begin
               vcount_d      = '0;
               frame_start_d = 1'b1;
            end else begin
               vcount_d = vcount_q + 11'd1;
            end
         end else begin
            hcount_d = hcount_q + 11'd1;
         end
      end
      hblnk_d = (hcount_d >= H_ACT);
      vblnk_d = (vcount_d >= V_ACT);
      hsync_d = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? HS_POL : ~HS_POL;
      vsync_d = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? VS_POL : ~VS_POL;
   end

   // Raster state; reset wins over ce and restarts at (0,0) without a frame pulse.
   always_ff @(posedge pclk) begin
      if (!rst) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         hsync_q       <= ~HS_POL;
         hblnk_q       <= 1'b0;
         vsync_q       <= ~VS_POL;
         vblnk_q       <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         hblnk_q       <= hblnk_d;
         vsync_q       <= vsync_d;
         vblnk_q       <= vblnk_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga.hcount      = hcount_q;
   assign vga.vcount      = vcount_q;
   assign vga.hsync       = hsync_q;
   assign vga.hblnk       = hblnk_q;
   assign vga.vsync       = vsync_q;
   assign vga.vblnk       = vblnk_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size mode instance plus a shrunken, inverted-polarity instance.
// Latency: expected bundle is the one presented after the edge following each stimulus.
// Backpressure: exercised through ce stalls, including a stall on the frame wrap.
module tb_vga_timing_gen;

   typedef struct {
      bit sel;    // 0 = full-size instance, 1 = small instance
      int tid;
      int h;
      int v;
      bit hs;
      bit vs;
      bit hb;
      bit vb;
      bit fs;
   } exp_t;

   logic pclk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   int   cur_tid = 0;
   int   checks = 0;
   int   passed = 0;
   exp_t q[$];
   exp_t e;

   always #5 pclk = ~pclk;

   vga_timing_gen_if vif_a();
   vga_timing_gen_if vif_b();

   vga_timing_gen u_a (
      .pclk (pclk),
      .rst  (rst_a),
      .vga  (vif_a.master)
   );

   // 16x10 raster: hsync 10..12, hblnk h>=8, vsync 6..7, vblnk v>=5, both active-low.
   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
      .V_ACTIVE (5), .V_FP (1), .V_SYNC (2), .V_BP (2),
      .HS_POL (1'b0), .VS_POL (1'b0)
   ) u_b (
      .pclk (pclk),
      .rst  (rst_b),
      .vga  (vif_b.master)
   );

   function automatic exp_t mk_a(input int h, input int v, input bit fs);
      exp_t x;
      x.sel = 1'b0; x.tid = cur_tid; x.h = h; x.v = v; x.fs = fs;
      x.hs  = (h >= 840 && h <= 967);
      x.vs  = (v >= 601 && v <= 604);
      x.hb  = (h >= 800);
      x.vb  = (v >= 600);
      return x;
   endfunction

   function automatic exp_t mk_b(input int h, input int v, input bit fs);
      exp_t x;
      x.sel = 1'b1; x.tid = cur_tid; x.h = h; x.v = v; x.fs = fs;
      x.hs  = !(h >= 10 && h <= 12);
      x.vs  = !(v >= 6 && v <= 7);
      x.hb  = (h >= 8);
      x.vb  = (v >= 5);
      return x;
   endfunction

   function automatic string tname(input int t);
      case (t)
         1: return "reset_a";
         2: return "line_a";
         3: return "ce_stall_a";
         4: return "midline_reset_a";
         5: return "reset_polarity_b";
         6: return "frame_b";
         7: return "wrap_stall_b";
         8: return "midframe_reset_b";
         default: return "misc";
      endcase
   endfunction

   // Drive one cycle of stimulus and queue the bundle expected after the next edge.
   task automatic step_a(input bit r, input bit c, input int h, input int v, input bit fs);
      @(negedge pclk);
      rst_a    = r;
      vif_a.ce = c;
      q.push_back(mk_a(h, v, fs));
   endtask

   task automatic step_b(input bit r, input bit c, input int h, input int v, input bit fs);
      @(negedge pclk);
      rst_b    = r;
      vif_b.ce = c;
      q.push_back(mk_b(h, v, fs));
   endtask

   // Monitor: one queued expectation per edge, compared just after the edge.
   always @(posedge pclk) begin
      #1;
      if (q.size() > 0) begin
         int ah, av;
         bit ahs, avs, ahb, avb, afs;
         e = q.pop_front();
         if (e.sel == 1'b0) begin
            ah = int'(vif_a.hcount); av = int'(vif_a.vcount);
            ahs = vif_a.hsync; avs = vif_a.vsync; ahb = vif_a.hblnk;
            avb = vif_a.vblnk; afs = vif_a.frame_start;
         end else begin
            ah = int'(vif_b.hcount); av = int'(vif_b.vcount);
            ahs = vif_b.hsync; avs = vif_b.vsync; ahb = vif_b.hblnk;
            avb = vif_b.vblnk; afs = vif_b.frame_start;
         end
         checks++;
         if (ah == e.h && av == e.v && ahs == e.hs && avs == e.vs &&
             ahb == e.hb && avb == e.vb && afs == e.fs) begin
            passed++;
         end else begin
            $display("FAIL %s: got h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b fs=%0b, want h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b fs=%0b",
                     tname(e.tid), ah, av, ahs, avs, ahb, avb, afs,
                     e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.fs);
         end
      end
   end

   initial begin
      vif_a.ce = 1'b0;
      vif_b.ce = 1'b0;

      // Reset held with ce=1: reset must win; then first enabled edge gives hcount=1.
      cur_tid = 1;
      repeat (5) step_a(1'b0, 1'b1, 0, 0, 1'b0);
      step_a(1'b1, 1'b1, 1, 0, 1'b0);

      // One full line: hblnk from 800, hsync 840..967, wrap 1055 -> (0,1).
      cur_tid = 2;
      for (int h = 2; h <= 1055; h++) step_a(1'b1, 1'b1, h, 0, 1'b0);
      step_a(1'b1, 1'b1, 0, 1, 1'b0);

      // ce pattern 1,0,0,1 from hcount=10: 10,11,11,11,12.
      cur_tid = 3;
      for (int h = 1; h <= 10; h++) step_a(1'b1, 1'b1, h, 1, 1'b0);
      step_a(1'b1, 1'b1, 11, 1, 1'b0);
      step_a(1'b1, 1'b0, 11, 1, 1'b0);
      step_a(1'b1, 1'b0, 11, 1, 1'b0);
      step_a(1'b1, 1'b1, 12, 1, 1'b0);

      // Reset at (500,1): straight to (0,0), no pulse, then normal counting.
      cur_tid = 4;
      for (int h = 13; h <= 500; h++) step_a(1'b1, 1'b1, h, 1, 1'b0);
      step_a(1'b0, 1'b1, 0, 0, 1'b0);
      step_a(1'b1, 1'b1, 1, 0, 1'b0);
      step_a(1'b1, 1'b1, 2, 0, 1'b0);
      step_a(1'b1, 1'b1, 3, 0, 1'b0);

      // Inverted polarity: syncs idle high out of reset.
      cur_tid = 5;
      repeat (3) step_b(1'b0, 1'b0, 0, 0, 1'b0);

      // Whole 160-cycle frame, back to (0,0) with a single frame_start, then (1,0).
      cur_tid = 6;
      for (int k = 1; k <= 160; k++) begin
         int p;
         p = k % 160;
         step_b(1'b1, 1'b1, p % 16, p / 16, p == 0);
      end
      step_b(1'b1, 1'b1, 1, 0, 1'b0);

      // Stall at (15,9): no pulse while held; one pulse on reaching (0,0); ce=0 kills it.
      cur_tid = 7;
      for (int p = 2; p <= 159; p++) step_b(1'b1, 1'b1, p % 16, p / 16, 1'b0);
      repeat (3) step_b(1'b1, 1'b0, 15, 9, 1'b0);
      step_b(1'b1, 1'b1, 0, 0, 1'b1);
      step_b(1'b1, 1'b0, 0, 0, 1'b0);
      step_b(1'b1, 1'b1, 1, 0, 1'b0);

      // Reset mid-frame at (5,3), inside vertical blank-free area.
      cur_tid = 8;
      for (int p = 2; p <= 53; p++) step_b(1'b1, 1'b1, p % 16, p / 16, 1'b0);
      step_b(1'b0, 1'b1, 0, 0, 1'b0);
      step_b(1'b1, 1'b1, 1, 0, 1'b0);
      step_b(1'b1, 1'b1, 2, 0, 1'b0);

      repeat (3) @(posedge pclk);
      #2;
      if (q.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
